mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master arbiter sharing one picorv32-style native memory port (valid/ready, addr, wdata, wstrb, rdata, instr) between two CPU cores.
- Slave side drives the shared memory block and the address decoder.
- Round-robin fairness, one transaction in flight, grant held until the slave's ready.
- Watchdog timeout completes a hung transaction with a fixed error word.

Parameters:
TIMEOUT, 1024, cycles in a grant state without mem_ready before forced completion; legal range 2..65535
TIMEOUT_DATA, 32'hDEADBEEF, rdata returned to the master on timeout

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active high
m0_valid  input  1  master 0 request; held high until m0_ready
m0_instr  input  1  master 0 instruction fetch flag
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_wstrb  input  4  master 0 byte strobes; 0 = read
m0_ready  output  1  master 0 completion, one-cycle pulse
m0_rdata  output  32  master 0 read data, valid while m0_ready is high
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as the m0_* ports, for master 1
mem_valid  output  1  to slave
mem_instr  output  1  to slave
mem_addr  output  32  to slave
mem_wdata  output  32  to slave
mem_wstrb  output  4  to slave
mem_ready  input  1  from slave
mem_rdata  input  32  from slave
grant  output  2  one-hot current owner: bit0 = master 0, bit1 = master 1
timeout_err  output  1  sticky; set on any timeout, cleared only by rst

Behaviour:
- States: IDLE, GNT0, GNT1. Registered: state, last (last-served master), wdog counter (16 bits), timeout_err.
- Reset (rst high at an edge):
  - state = IDLE, last = 1 (master 0 wins the first tie), wdog = 0, timeout_err = 0.
  - Consequently grant = 0, mem_valid = 0, m0_ready = m1_ready = 0.
  - Reset mid-transaction abandons it silently; no ready pulse is issued.
- IDLE transitions:
  - Only m0_valid -> GNT0. Only m1_valid -> GNT1.
  - Both valid -> the master != last.
  - Neither valid -> stay.
  - Arbitration costs exactly one cycle; mem_valid is never high in IDLE.
- GNTn:
  - grant = one-hot n.
  - mem_valid = mn_valid; mem_addr, mem_wdata, mem_wstrb, mem_instr come combinationally from master n.
  - While not granted, slave-side outputs are 0.
  - mn_ready = mem_ready and mn_rdata = mem_rdata, same cycle (zero added latency).
  - Non-granted master: ready = 0, rdata = 0.
- Completion (mem_ready high in GNTn): next state IDLE, last = n, wdog = 0.
  - Minimum master-visible latency = 1 arbitration cycle + slave latency.
  - Back-to-back requests from one master therefore have one idle bubble.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- Watchdog:
  - wdog increments each GNTn cycle without mem_ready.
  - When wdog == TIMEOUT-1 and mem_ready is low:
    - mn_ready = 1, mn_rdata = TIMEOUT_DATA.
    - mem_valid is forced to 0 that cycle.
    - timeout_err is set; next state IDLE, last = n, wdog = 0.
  - mem_ready high on that same cycle takes priority: normal completion, no error.
- Protocol violation (mn_valid drops while in GNTn without ready): return to IDLE next cycle, last unchanged, no ready pulse.
- mem_ready arriving in IDLE is ignored.

Test Plan:
1. Master 0 read only, addr 0x100; slave ready 2 cycles after mem_valid, rdata 0x12345678 -> grant = 01 one cycle after m0_valid; m0_ready pulses one cycle with m0_rdata = 0x12345678; m1_ready stays 0.
2. Both masters request continuously after reset, single-cycle slave -> grant sequence 01,00,10,00,01,00,10; m0 served first; each ready pulse goes only to the owner.
3. Master 1 writes 0xA5A5A5A5 with wstrb = 0011 at 0x40 while master 0 is idle -> slave sees mem_wstrb = 0011 and mem_wdata = 0xA5A5A5A5; mem_instr follows m1_instr.
4. Slave never readies, TIMEOUT = 8, master 0 request -> m0_ready pulses on the 8th GNT0 cycle with m0_rdata = 0xDEADBEEF; timeout_err = 1 and stays 1; a following master 1 request completes normally.
5. Assert rst during GNT1 with the slave stalled -> next cycle grant = 00, mem_valid = 0, no ready pulse, timeout_err = 0; the next simultaneous request is granted to master 0.
6. mem_ready and watchdog expiry in the same cycle (TIMEOUT = 4, ready on the 4th grant cycle) -> master receives mem_rdata, not TIMEOUT_DATA; timeout_err stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets two picorv32-style masters share one native memory port.
// Only one transaction is in flight at a time, and a watchdog completes a hung transaction with an error word.
module mem_arbiter #(
  parameter int unsigned TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned WDOG_W    = 16;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                terr_q, terr_d;

  logic                granted;
  logic                sel_m1;
  logic                own_valid;
  logic                own_instr;
  logic [31:0]         own_addr;
  logic [31:0]         own_wdata;
  logic [3:0]          own_wstrb;
  logic                expire;
  logic                own_ready;
  logic [31:0]         own_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      terr_q  <= terr_d;
    end
  end

  // Request lines of the current owner. expire only fires while the owner is still requesting.
  always_comb begin
    granted   = (state_q == GNT0) || (state_q == GNT1);
    sel_m1    = (state_q == GNT1);
    own_valid = sel_m1 ? m1_valid : m0_valid;
    own_instr = sel_m1 ? m1_instr : m0_instr;
    own_addr  = sel_m1 ? m1_addr  : m0_addr;
    own_wdata = sel_m1 ? m1_wdata : m0_wdata;
    own_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;
    expire    = granted && own_valid && !mem_ready && (wdog_q == WDOG_LAST);
  end

  // Next-state logic. Within a grant state the priority is: slave ready, then dropped request, then watchdog expiry.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (m0_valid && m1_valid) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_valid) begin
          state_d = GNT0;
        end else if (m1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (mem_ready) begin
          state_d = IDLE;
          last_d  = sel_m1;
          wdog_d  = '0;
        end else if (!own_valid) begin
          state_d = IDLE;
          wdog_d  = '0;
        end else if (expire) begin
          state_d = IDLE;
          last_d  = sel_m1;
          wdog_d  = '0;
          terr_d  = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  // Output logic. Slave-side signals and the master return path are zero unless a master is granted.
  always_comb begin
    grant     = 2'b00;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    own_ready = 1'b0;
    own_rdata = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    if (granted) begin
      grant     = sel_m1 ? 2'b10 : 2'b01;
      mem_valid = own_valid && !expire;
      mem_instr = own_instr;
      mem_addr  = own_addr;
      mem_wdata = own_wdata;
      mem_wstrb = own_wstrb;
      own_ready = mem_ready || expire;
      own_rdata = expire ? TIMEOUT_DATA : mem_rdata;
      if (sel_m1) begin
        m1_ready = own_ready;
        m1_rdata = own_rdata;
      end else begin
        m0_ready = own_ready;
        m0_rdata = own_rdata;
      end
    end
  end

  assign timeout_err = terr_q;

endmodule
